wb_arbiter: RTL and testbench

- Write-back stage directly upstream of the 32x32 register file.
- Merges two result sources onto the register file's single write port (WE3/A3/WD3):
  - single-cycle ALU results;
  - variable-latency memory load results, buffered in a small in-order queue.
- Preserves architectural write order for same-register conflicts and guarantees the load queue cannot starve.

---
 rtl/wb_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges single-cycle ALU results and queued load results
// onto the register file's single write port, preserving same-register write order.
module wb_arbiter #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   output logic                     alu_stall,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [4:0]               mem_rd,
   input  logic [31:0]              mem_data,
   output logic                     WE3,
   output logic [4:0]               A3,
   output logic [31:0]              WD3,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     proto_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_MAX) + 1;
   localparam logic [CW-1:0] Q_FULL    = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX - 1);

   logic [4:0]       q_rd   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [DEPTH-1:0] q_vld;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [SW-1:0]    starve;
   logic [SW-1:0]    starve_next;

   logic alu_acc;
   logic alu_wr;
   logic q_empty;
   logic deq;
   logic enq;
   logic enq_live;

   // Ready depends only on registered occupancy, so a full queue stays closed
   // even in a cycle that also dequeues.
   assign mem_ready = rst & (q_count < Q_FULL);

   always_comb begin
      alu_acc     = alu_valid & ~alu_stall;
      alu_wr      = alu_acc & (alu_rd != '0);
      q_empty     = (q_count == '0);
      deq         = ~q_empty & (alu_stall | ~alu_acc);
      enq         = mem_valid & mem_ready & (mem_rd != '0);
      // A load arriving alongside an ALU write to the same register is the older value.
      enq_live    = ~(alu_wr & (alu_rd == mem_rd));
      starve_next = starve;
      if (deq | q_empty) begin
         starve_next = '0;
      end else if (alu_acc) begin
         starve_next = starve + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_rd[tail]   <= mem_rd;
         q_data[tail] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_vld     <= '0;
         head      <= '0;
         tail      <= '0;
         q_count   <= '0;
         starve    <= '0;
         alu_stall <= 1'b0;
         proto_err <= 1'b0;
         WE3       <= 1'b0;
         A3        <= '0;
         WD3       <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_wr && (q_rd[i] == alu_rd)) begin
               q_vld[i] <= 1'b0;
            end
         end
         if (enq) begin
            q_vld[tail] <= enq_live;
            tail        <= tail + PW'(1);
         end
         if (deq) begin
            head <= head + PW'(1);
         end

         case ({enq, deq})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase

         starve    <= starve_next;
         alu_stall <= (starve_next == STARVE_TOP);
         proto_err <= proto_err | (alu_valid & alu_stall);

         if (deq) begin
            WE3 <= q_vld[head];
            if (q_vld[head]) begin
               A3  <= q_rd[head];
               WD3 <= q_data[head];
            end
         end else if (alu_acc) begin
            WE3 <= (alu_rd != '0);
            if (alu_rd != '0) begin
               A3  <= alu_rd;
               WD3 <= alu_data;
            end
         end else begin
            WE3 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked each
// cycle against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;

   localparam int unsigned DEPTH      = 4;
   localparam int unsigned STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid, alu_stall, mem_valid, mem_ready, WE3, proto_err;
   logic [4:0]  alu_rd, mem_rd, A3;
   logic [31:0] alu_data, mem_data, WD3;
   logic [$clog2(DEPTH):0] q_count;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .WE3(WE3), .A3(A3), .WD3(WD3), .q_count(q_count), .proto_err(proto_err)
   );

   typedef struct { logic [4:0] rd; logic [31:0] data; bit live; } ld_t;
   typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;

   ld_t         mq[$];
   wr_t         wlog[$];
   int unsigned m_starve;
   bit          m_stall, m_perr, m_we;
   logic [4:0]  m_a3;
   logic [31:0] m_wd3;
   int          vectors = 0;
   int          errors  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
      m_perr   = 0;
      m_we     = 0;
   endfunction

   // One cycle of the write-back rules, applied to the inputs currently driven.
   function automatic void model_tick();
      int unsigned n;
      bit acc, deq, ready, alu_w;
      ld_t h;
      n     = mq.size();
      ready = (n < DEPTH);
      acc   = alu_valid && !m_stall;
      alu_w = acc && (alu_rd != 5'd0);
      if (alu_valid && m_stall) m_perr = 1;
      deq   = (n != 0) && (m_stall || !acc);
      m_we  = 0;
      if (deq) begin
         h     = mq.pop_front();
         m_we  = h.live;
         m_a3  = h.rd;
         m_wd3 = h.data;
      end else if (alu_w) begin
         m_we  = 1;
         m_a3  = alu_rd;
         m_wd3 = alu_data;
      end
      if (alu_w)
         foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
      if (mem_valid && ready && (mem_rd != 5'd0))
         mq.push_back('{rd: mem_rd, data: mem_data,
                        live: !(alu_w && (alu_rd == mem_rd))});
      if (deq || n == 0) m_starve = 0;
      else if (acc) m_starve++;
      m_stall = (m_starve == STARVE_MAX - 1);
   endfunction

   task automatic check_outputs();
      chk("we3", 32'(WE3), 32'(m_we));
      if (m_we) begin
         chk("a3", 32'(A3), 32'(m_a3));
         chk("wd3", WD3, m_wd3);
      end
      chk("alu_stall", 32'(alu_stall), 32'(m_stall));
      chk("q_count", 32'(q_count), 32'(mq.size()));
      chk("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
      chk("proto_err", 32'(proto_err), 32'(m_perr));
      if (WE3 === 1'b1) wlog.push_back('{rd: A3, data: WD3});
   endtask

   task automatic step();
      model_tick();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md);
      alu_valid = av;  alu_rd = ard;  alu_data = ad;
      mem_valid = mv;  mem_rd = mrd;  mem_data = md;
   endtask

   task automatic idle(input int n);
      set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      repeat (n) step();
   endtask

   // Asserts reset between edges, holds it across one edge, then releases.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_q_count", 32'(q_count), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      chk("rst_stall", 32'(alu_stall), 32'd0);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_we3", 32'(WE3), 32'd0);
      rst = 1'b1;
      #1;
      chk("post_rst_ready", 32'(mem_ready), 32'd1);
   endtask

   function automatic int count_rd(input logic [4:0] rd);
      int c = 0;
      foreach (wlog[i]) if (wlog[i].rd == rd) c++;
      return c;
   endfunction

   function automatic logic [31:0] data_of(input logic [4:0] rd);
      logic [31:0] d = '0;
      foreach (wlog[i]) if (wlog[i].rd == rd) d = wlog[i].data;
      return d;
   endfunction

   initial begin
      int stall_at;
      int stall_pulses;
      int pct;
      bit av;

      set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      do_reset();

      // ALU write and the rd=0 case
      set_in(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
      step();
      chk("alu_we3", 32'(WE3), 32'd1);
      chk("alu_a3", 32'(A3), 32'd5);
      chk("alu_wd3", WD3, 32'hDEADBEEF);
      set_in(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0);
      step();
      chk("alu_rd0_we3", 32'(WE3), 32'd0);
      idle(1);

      // Load burst with ALU idle never blocks
      for (int i = 0; i < 6; i++) begin
         set_in(0, 5'd0, 32'd0, 1, 5'(10 + i), 32'(i));
         step();
         chk("burst_ready", 32'(mem_ready), 32'd1);
      end
      idle(2);

      // Fill behind busy ALU, fifth load waits, then in-order drain
      for (int i = 1; i <= 4; i++) begin
         set_in(1, 5'd20, 32'(i), 1, 5'(i), 32'h11 * 32'(i));
         step();
      end
      chk("full_count", 32'(q_count), 32'd4);
      chk("full_ready", 32'(mem_ready), 32'd0);
      set_in(1, 5'd20, 32'd5, 1, 5'd5, 32'h55);
      step();
      chk("full_hold", 32'(q_count), 32'd4);
      wlog.delete();
      set_in(0, 5'd0, 32'd0, 1, 5'd5, 32'h55);
      step();
      step();
      idle(6);
      chk("drain_n", 32'(wlog.size()), 32'd5);
      for (int i = 0; i < 4; i++) begin
         if (i < wlog.size()) begin
            chk("drain_rd", 32'(wlog[i].rd), 32'(i + 1));
            chk("drain_data", wlog[i].data, 32'h11 * 32'(i + 1));
         end
      end

      // Hazard kill
      wlog.delete();
      set_in(1, 5'd20, 32'hA, 1, 5'd7, 32'hAAAA);
      step();
      set_in(1, 5'd7, 32'hBBBB, 0, 5'd0, 32'd0);
      step();
      idle(4);
      chk("kill_x7_n", 32'(count_rd(5'd7)), 32'd1);
      chk("kill_x7_data", data_of(5'd7), 32'hBBBB);

      // Same-cycle conflict
      wlog.delete();
      set_in(1, 5'd9, 32'd2, 1, 5'd9, 32'd1);
      step();
      idle(3);
      chk("same_x9_n", 32'(count_rd(5'd9)), 32'd1);
      chk("same_x9_data", data_of(5'd9), 32'd2);

      // Starvation with alu_valid held high regardless of alu_stall
      wlog.delete();
      stall_at = -1;
      stall_pulses = 0;
      for (int k = 0; k < 14; k++) begin
         set_in(1, 5'd3, 32'h100 + 32'(k), k == 0, 5'd12, 32'hC);
         step();
         if (alu_stall === 1'b1) begin
            stall_pulses++;
            if (stall_at < 0) stall_at = k;
         end
      end
      chk("starve_at", 32'(stall_at), 32'(STARVE_MAX - 1));
      chk("starve_pulses", 32'(stall_pulses), 32'd1);
      chk("starve_load_n", 32'(count_rd(5'd12)), 32'd1);
      chk("starve_load_data", data_of(5'd12), 32'hC);
      idle(3);
      chk("proto_sticky", 32'(proto_err), 32'd1);

      // Reset mid-stream discards queued loads
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 5'd21, 32'(i), 1, 5'(13 + i), 32'hF0 + 32'(i));
         step();
      end
      chk("pre_rst_count", 32'(q_count), 32'd3);
      set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      do_reset();
      wlog.delete();
      idle(6);
      chk("rst_no_old", 32'(count_rd(5'd13) + count_rd(5'd14) + count_rd(5'd15)), 32'd0);

      // Random traffic in windows of varying ALU pressure
      for (int w = 0; w < 8; w++) begin
         pct = (w % 2 == 0) ? 40 : 95;
         for (int n = 0; n < 80; n++) begin
            av = ($urandom_range(99) < pct) && !m_stall;
            set_in(av, 5'($urandom_range(7)), $urandom,
                   $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom);
            step();
         end
      end
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
